// File: rtl/dropout_pkg.sv
// Shared types, constants and helper functions for the dropout mask controller.
// The LFSR polynomial is fixed for a 16-bit register; widths follow from the constants below.
package dropout_pkg;

   localparam int N_NEURONS = 8;
   localparam int LFSR_W    = 16;
   localparam int RATE_W    = 8;
   localparam int IDX_W     = $clog2(N_NEURONS);
   localparam int CNT_W     = $clog2(N_NEURONS + 1);

   localparam logic [LFSR_W-1:0] LFSR_POLY    = 16'hB400;
   localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;

   typedef enum logic [1:0] {
      IDLE,
      GEN,
      DONE
   } dropout_state_t;

   // One Galois step: shift right, fold the polynomial in when a one drops out.
   function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
      return (s >> 1) ^ (s[0] ? LFSR_POLY : '0);
   endfunction

   function automatic logic [CNT_W-1:0] count_zeros(input logic [N_NEURONS-1:0] m);
      logic [CNT_W-1:0] c;
      c = '0;
      for (int i = 0; i < N_NEURONS; i++) begin
         if (!m[i]) c = c + CNT_W'(1);
      end
      return c;
   endfunction

endpackage

// File: rtl/dropout_lfsr.sv
// 16-bit Galois LFSR with seed load (zero seed maps to DEFAULT_SEED) and step enable.
// Exposes only the low RATE_W bits, which is all the comparator consumes.
module dropout_lfsr
   import dropout_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              load,
   input  logic [LFSR_W-1:0] seed,
   input  logic              step,
   output logic [RATE_W-1:0] r
);

   logic [LFSR_W-1:0] lfsr_q;
   logic [LFSR_W-1:0] lfsr_d;

   // NOTE: every always_comb output gets a default on entry so no path infers a latch.
   always_comb begin
      lfsr_d = lfsr_q;
      if (load) begin
         lfsr_d = (seed == '0) ? DEFAULT_SEED : seed;
      end else if (step) begin
         lfsr_d = lfsr_step(lfsr_q);
      end
   end

   // NOTE: sequential state uses non-blocking assignment so all flops update together.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) lfsr_q <= DEFAULT_SEED;
      else          lfsr_q <= lfsr_d;
   end

   assign r = lfsr_q[RATE_W-1:0];

endmodule

// File: rtl/dropout_mask_ctrl.sv
// Per-frame dropout keep-mask generator: IDLE/GEN/DONE FSM, one mask bit per GEN cycle.
// Optional macro DROPOUT_MIN_KEEP_EN forces bit 0 on when a training mask comes out all-zero.
module dropout_mask_ctrl
   import dropout_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 enable,
   input  logic [RATE_W-1:0]    rate,
   input  logic                 seed_load,
   input  logic [LFSR_W-1:0]    seed,
   input  logic                 req_valid,
   output logic                 req_ready,
   output logic                 mask_valid,
   input  logic                 mask_ready,
   output logic [N_NEURONS-1:0] mask,
   output logic [CNT_W-1:0]     drop_count
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

   dropout_state_t       state_q, state_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [N_NEURONS-1:0] mask_q, mask_d;
   logic [CNT_W-1:0]     drop_count_q, drop_count_d;
   logic                 mask_valid_q, mask_valid_d;
   logic                 mode_q, mode_d;
   logic [RATE_W-1:0]    rate_q, rate_d;
   logic                 rst_done_q;

   logic                 accept;
   logic                 lfsr_load;
   logic                 lfsr_step_en;
   logic [RATE_W-1:0]    lfsr_r;
   logic [N_NEURONS-1:0] mask_gen;

   dropout_lfsr u_lfsr (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (lfsr_load),
      .seed    (seed),
      .step    (lfsr_step_en),
      .r       (lfsr_r)
   );

   // A seed load owns the IDLE cycle, so a coincident request waits one cycle.
   assign req_ready = rst_done_q && (state_q == IDLE) && !seed_load;
   assign accept    = req_valid && req_ready;
   assign lfsr_load = seed_load && (state_q == IDLE);

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      mask_d       = mask_q;
      drop_count_d = drop_count_q;
      mask_valid_d = mask_valid_q;
      mode_d       = mode_q;
      rate_d       = rate_q;
      lfsr_step_en = 1'b0;
      mask_gen     = mask_q;

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               mode_d = enable;
               rate_d = rate;
               idx_d  = '0;
               if (enable) begin
                  mask_d  = '0;
                  state_d = GEN;
               end else begin
                  mask_d       = '1;
                  drop_count_d = '0;
                  mask_valid_d = 1'b1;
                  state_d      = DONE;
               end
            end
         end
         GEN: begin
            lfsr_step_en     = 1'b1;
            mask_gen[idx_q]  = mode_q ? (lfsr_r >= rate_q) : 1'b1;
            idx_d            = idx_q + IDX_W'(1);
            if (idx_q == LAST_IDX) begin
`ifdef DROPOUT_MIN_KEEP_EN
               if (mask_gen == '0) mask_gen[0] = 1'b1;
`endif
               drop_count_d = count_zeros(mask_gen);
               mask_valid_d = 1'b1;
               idx_d        = '0;
               state_d      = DONE;
            end
            mask_d = mask_gen;
         end
         DONE: begin
            if (mask_ready) begin
               mask_valid_d = 1'b0;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         mask_q       <= '0;
         drop_count_q <= '0;
         mask_valid_q <= 1'b0;
         mode_q       <= 1'b0;
         rate_q       <= '0;
         rst_done_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         mask_q       <= mask_d;
         drop_count_q <= drop_count_d;
         mask_valid_q <= mask_valid_d;
         mode_q       <= mode_d;
         rate_q       <= rate_d;
         rst_done_q   <= 1'b1;
      end
   end

   assign mask       = mask_q;
   assign drop_count = drop_count_q;
   assign mask_valid = mask_valid_q;

endmodule

// File: tb/tb_dropout_mask_ctrl.sv
// Directed bench for dropout_mask_ctrl: vector table plus hand-written corner sequences.
// Compile with +define+DROPOUT_MIN_KEEP_EN to check the min-keep build.
module tb_dropout_mask_ctrl;

   logic        clk;
   logic        reset_n;
   logic        enable;
   logic [7:0]  rate;
   logic        seed_load;
   logic [15:0] seed;
   logic        req_valid;
   logic        req_ready;
   logic        mask_valid;
   logic        mask_ready;
   logic [7:0]  mask;
   logic [3:0]  drop_count;

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0] m_lfsr;

   dropout_mask_ctrl dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .enable     (enable),
      .rate       (rate),
      .seed_load  (seed_load),
      .seed       (seed),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .mask_valid (mask_valid),
      .mask_ready (mask_ready),
      .mask       (mask),
      .drop_count (drop_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference LFSR model: Galois right shift with taps 0xB400.
   function automatic logic [15:0] ref_step(input logic [15:0] s);
      logic [15:0] n;
      n = {1'b0, s[15:1]};
      if (s[0]) n = n ^ 16'hB400;
      return n;
   endfunction

   task automatic model_frame(input logic en, input logic [7:0] r,
                              output logic [7:0] m, output logic [3:0] dc);
      m  = 8'hFF;
      dc = 4'd0;
      if (en) begin
         for (int k = 0; k < 8; k++) begin
            m[k]   = (m_lfsr[7:0] >= r);
            m_lfsr = ref_step(m_lfsr);
         end
`ifdef DROPOUT_MIN_KEEP_EN
         if (m == 8'h00) m = 8'h01;
`endif
         dc = 4'd0;
         for (int k = 0; k < 8; k++) if (!m[k]) dc = dc + 4'd1;
      end
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      #1;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!req_ready) check("req_ready_wait", {31'd0, req_ready}, 32'd1);
   endtask

   task automatic wait_valid(output int lat);
      lat = 1;
      while (!mask_valid && lat < 50) begin
         @(negedge clk);
         lat++;
      end
   endtask

   // Called at a negedge; returns once mask_valid is seen (or the bound expires).
   task automatic start_frame(input logic en, input logic [7:0] r,
                              output logic [7:0] m, output logic [3:0] dc, output int lat);
      wait_ready();
      req_valid = 1'b1;
      enable    = en;
      rate      = r;
      @(negedge clk);
      req_valid = 1'b0;
      enable    = ~en;
      rate      = ~r;
      wait_valid(lat);
      m  = mask;
      dc = drop_count;
   endtask

   task automatic finish_frame();
      mask_ready = 1'b1;
      @(negedge clk);
      mask_ready = 1'b0;
      #1;
      check("valid_drop_after_xfer", {31'd0, mask_valid}, 32'd0);
      check("ready_rise_after_xfer", {31'd0, req_ready}, 32'd1);
   endtask

   task automatic do_seed(input logic [15:0] s);
      seed_load = 1'b1;
      seed      = s;
      #1;
      check("req_ready_low_on_seed", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
      seed_load = 1'b0;
      m_lfsr    = (s == 16'h0000) ? 16'hACE1 : s;
   endtask

   typedef struct {
      logic        en;
      logic [7:0]  rate;
      logic        do_seed;
      logic [15:0] seed;
      logic        use_model;
      logic [7:0]  exp_mask;
      logic [3:0]  exp_dc;
   } vec_t;

   vec_t        vecs[8];
   logic [7:0]  got_mask[8];

   initial begin
      logic [7:0] m, em, ref_m;
      logic [3:0] dc, edc;
      int         lat;

      vecs[0] = '{en:1'b0, rate:8'hFF, do_seed:1'b0, seed:16'h0000, use_model:1'b0, exp_mask:8'hFF, exp_dc:4'd0};
      vecs[1] = '{en:1'b1, rate:8'h80, do_seed:1'b0, seed:16'h0000, use_model:1'b1, exp_mask:8'h00, exp_dc:4'd0};
      vecs[2] = '{en:1'b1, rate:8'h00, do_seed:1'b0, seed:16'h0000, use_model:1'b0, exp_mask:8'hFF, exp_dc:4'd0};
      vecs[3] = '{en:1'b1, rate:8'h80, do_seed:1'b1, seed:16'h1234, use_model:1'b1, exp_mask:8'h00, exp_dc:4'd0};
      vecs[4] = '{en:1'b1, rate:8'h80, do_seed:1'b1, seed:16'h1234, use_model:1'b1, exp_mask:8'h00, exp_dc:4'd0};
      vecs[5] = '{en:1'b1, rate:8'hFF, do_seed:1'b1, seed:16'h0000, use_model:1'b1, exp_mask:8'h00, exp_dc:4'd0};
      vecs[6] = '{en:1'b1, rate:8'h40, do_seed:1'b0, seed:16'h0000, use_model:1'b1, exp_mask:8'h00, exp_dc:4'd0};
      vecs[7] = '{en:1'b0, rate:8'h00, do_seed:1'b0, seed:16'h0000, use_model:1'b0, exp_mask:8'hFF, exp_dc:4'd0};

      reset_n    = 1'b0;
      enable     = 1'b0;
      rate       = 8'h00;
      seed_load  = 1'b0;
      seed       = 16'h0000;
      req_valid  = 1'b0;
      mask_ready = 1'b0;
      m_lfsr     = 16'hACE1;

      repeat (3) @(negedge clk);
      check("reset_mask", {24'd0, mask}, 32'h0);
      check("reset_drop_count", {28'd0, drop_count}, 32'h0);
      check("reset_mask_valid", {31'd0, mask_valid}, 32'h0);
      reset_n = 1'b1;
      @(negedge clk);

      // Table-driven frames.
      for (int i = 0; i < 8; i++) begin
         if (vecs[i].do_seed) do_seed(vecs[i].seed);
         model_frame(vecs[i].en, vecs[i].rate, em, edc);
         if (!vecs[i].use_model) begin
            em  = vecs[i].exp_mask;
            edc = vecs[i].exp_dc;
         end
         start_frame(vecs[i].en, vecs[i].rate, m, dc, lat);
         got_mask[i] = m;
         check($sformatf("vec%0d_latency", i), lat, vecs[i].en ? 32'd9 : 32'd1);
         check($sformatf("vec%0d_mask", i), {24'd0, m}, {24'd0, em});
         check($sformatf("vec%0d_drop_count", i), {28'd0, dc}, {28'd0, edc});
         finish_frame();
      end
      check("reseed_repeatable", {24'd0, got_mask[4]}, {24'd0, got_mask[3]});

      // seed_load and req_valid together: seed wins, request accepted next cycle.
      seed_load = 1'b1;
      seed      = 16'h1234;
      req_valid = 1'b1;
      enable    = 1'b1;
      rate      = 8'h80;
      #1;
      check("simul_req_ready_low", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
      seed_load = 1'b0;
      m_lfsr    = 16'h1234;
      #1;
      check("simul_req_ready_next", {31'd0, req_ready}, 32'd1);
      @(negedge clk);
      req_valid = 1'b0;
      wait_valid(lat);
      model_frame(1'b1, 8'h80, em, edc);
      check("simul_latency", lat, 32'd9);
      check("simul_mask", {24'd0, mask}, {24'd0, em});
      check("simul_mask_vs_seeded", {24'd0, mask}, {24'd0, got_mask[3]});
      finish_frame();

      // Stall in DONE for 20 cycles with requests and seed loads that must be ignored.
      model_frame(1'b1, 8'h55, em, edc);
      start_frame(1'b1, 8'h55, ref_m, dc, lat);
      check("stall_mask", {24'd0, ref_m}, {24'd0, em});
      check("stall_drop_count", {28'd0, dc}, {28'd0, edc});
      for (int i = 0; i < 20; i++) begin
         req_valid = 1'b1;
         seed_load = i[0];
         seed      = 16'h0F0F;
         @(negedge clk);
         check("stall_mask_stable", {24'd0, mask}, {24'd0, ref_m});
         check("stall_valid_held", {31'd0, mask_valid}, 32'd1);
         check("stall_req_ready_low", {31'd0, req_ready}, 32'd0);
      end
      req_valid = 1'b0;
      seed_load = 1'b0;
      finish_frame();
      model_frame(1'b1, 8'h80, em, edc);
      start_frame(1'b1, 8'h80, m, dc, lat);
      check("post_stall_mask", {24'd0, m}, {24'd0, em});
      finish_frame();

      // Asynchronous reset at GEN index 4.
      wait_ready();
      req_valid = 1'b1;
      enable    = 1'b1;
      rate      = 8'h80;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (4) @(negedge clk);
      check("midgen_not_valid", {31'd0, mask_valid}, 32'd0);
      reset_n = 1'b0;
      #1;
      check("midgen_reset_mask", {24'd0, mask}, 32'h0);
      check("midgen_reset_valid", {31'd0, mask_valid}, 32'h0);
      check("midgen_reset_drop_count", {28'd0, drop_count}, 32'h0);
      check("midgen_reset_req_ready", {31'd0, req_ready}, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      m_lfsr  = 16'hACE1;
      @(negedge clk);

      model_frame(1'b1, 8'hFF, em, edc);
      start_frame(1'b1, 8'hFF, m, dc, lat);
      check("post_reset_rateff_mask", {24'd0, m}, {24'd0, em});
      check("post_reset_rateff_dc", {28'd0, dc}, {28'd0, edc});
      finish_frame();
      model_frame(1'b1, 8'h80, em, edc);
      start_frame(1'b1, 8'h80, m, dc, lat);
      check("post_reset_mask", {24'd0, m}, {24'd0, em});
      check("post_reset_dc", {28'd0, dc}, {28'd0, edc});
      finish_frame();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
